ysyx_22050612_ctrl: RTL and testbench
=====================================

# ysyx_22050612_ctrl

Multi-cycle control sequencer for the RV64 core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the request and write-enable strobes for instruction memory, data memory, the register file and the PC. It latches the fetched instruction that feeds the decoder, turns decoder class flags into sequencing decisions, and keeps cycle and retired-instruction counters. It also halts the core on ebreak, on an illegal instruction, or on a bus timeout.

## Interface
Parameters:
- TIMEOUT, default 255: maximum wait cycles for an imem/dmem response before the core halts with a timeout.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction fetch request
- imem_rvalid  in  1  instruction response valid
- imem_rdata  in  32  instruction word
- inst_q  out  32  latched instruction, fed to the decoder
- dec_is_load  in  1  decoder: load class
- dec_is_store  in  1  decoder: store class
- dec_rf_we  in  1  decoder: instruction writes rd
- dec_ebreak  in  1  decoder: inst_q == 0x00100073
- dec_illegal  in  1  decoder: no opcode matched
- dmem_req  out  1  data access request
- dmem_we  out  1  data access is a store
- dmem_rvalid  in  1  data response or store acknowledge
- rf_we  out  1  register-file write strobe
- pc_we  out  1  PC update strobe
- halted  out  1  core stopped
- halt_code  out  2  0 running, 1 ebreak, 2 illegal, 3 timeout
- mcycle  out  64  cycle counter
- minstret  out  64  retired-instruction counter

## Operation
- States: IDLE, IF, ID, EX, MEM, WB, HALT.
- Reset values:
  - State is IDLE.
  - inst_q = 0, halted = 0, halt_code = 0.
  - mcycle = 0, minstret = 0.
  - All strobes = 0.
- IDLE: always goes to IF on the next cycle.
- IF:
  - imem_req = 1.
  - On imem_rvalid, latch imem_rdata into inst_q and go to ID.
- ID: one cycle; decoder flags are evaluated from the stable inst_q.
  - dec_ebreak → HALT, code 1, minstret + 1.
  - Otherwise dec_illegal → HALT, code 2.
  - Otherwise → EX.
- EX: one cycle.
  - If dec_is_load or dec_is_store → MEM.
  - Otherwise → WB.
- MEM:
  - dmem_req = 1, dmem_we = dec_is_store.
  - On dmem_rvalid → WB.
- WB: one cycle.
  - pc_we = 1.
  - rf_we = dec_rf_we & ~dec_is_store.
  - minstret + 1, then → IF.
- HALT:
  - Terminal until reset; halted = 1.
  - All strobes are 0.
  - Counters freeze.
- Timeout:
  - A wait counter clears on entry to IF or MEM and increments each cycle the response is absent.
  - When wait == TIMEOUT and the response is absent, go to HALT with code 3.
  - Counter width is clog2(TIMEOUT+1).
- mcycle: increments every cycle the state is not HALT.
- Both 64-bit counters wrap modulo 2^64.

## Timing
- Strobes are Moore outputs decoded from the state register; no combinational path from any *_rvalid to any *_req.
- Minimum latency, non-memory instruction with a same-cycle imem response: 4 cycles (IF, ID, EX, WB).
- Load or store with same-cycle responses: 5 cycles.
- imem_req and dmem_req stay high continuously until the matching rvalid is sampled; they drop the cycle after.
- rvalid arriving while no request is outstanding is ignored.
- rvalid arriving in the same cycle that wait == TIMEOUT wins: the response is accepted and there is no halt.
- inst_q changes only on the IF→ID transition.
- Asynchronous reset mid-operation:
  - State and outputs clear immediately.
  - In-flight responses that arrive after reset release are ignored until IF re-issues its request.
- Decoder flags are sampled only in ID, EX, MEM and WB.

## Structure
- Package ysyx_22050612_ctrl_pkg holds:
  - the state enum (3-bit encoding);
  - the halt_code constants HALT_NONE, HALT_EBREAK, HALT_ILLEGAL, HALT_TIMEOUT;
  - the EBREAK_INST constant 32'h00100073.
- Sub-module ysyx_22050612_perf_cnt contains the two 64-bit counters.
  - Inputs: en_cycle, en_retire.
  - Shared by any later pipelined control block.

## Test plan
- **addi, same-cycle responses.** Reset, then inst 0x00100093 with imem_rvalid high every request cycle.
  - Required: pc_we and rf_we pulse in cycle 4 after IDLE.
  - Required: minstret = 1 and mcycle = 5 after the first WB.
- **sd store.** Inst 0x00B13023 with dmem_rvalid delayed 3 cycles.
  - Required: dmem_req = 1 and dmem_we = 1 for exactly 4 cycles.
  - Required: rf_we stays 0 in WB, pc_we = 1.
- **ebreak.** Inst 0x00100073.
  - Required: halted = 1 and halt_code = 1 two cycles after imem_rvalid.
  - Required: minstret + 1, and mcycle frozen afterwards.
- **Timeout.** TIMEOUT = 3, imem_rvalid held low.
  - Required: HALT with code 3 after 4 IF cycles.
  - Variant: rvalid asserted exactly on the 4th IF cycle gives no halt.
- **Reset mid-MEM.** Drop rst_n during a ld wait, then deliver a late dmem_rvalid after release.
  - Required: all outputs are 0 asynchronously.
  - Required: the stale rvalid is ignored, and imem_req reasserts 1 cycle after IDLE.

Source files
------------

// File: rtl/ysyx_22050612_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050612_ctrl_pkg
//  Purpose  : Shared types and constants for the multi-cycle control
//             sequencer of the RV64 core. It holds the sequencer state
//             encoding, the halt-reason codes and the ebreak encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ysyx_22050612_ctrl_pkg;

   // Sequencer states. The encoding is fixed so that state values stay the
   // same in every build and can be read directly from a waveform.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_IF   = 3'd1,
      S_ID   = 3'd2,
      S_EX   = 3'd3,
      S_MEM  = 3'd4,
      S_WB   = 3'd5,
      S_HALT = 3'd6
   } ctrl_state_e;

   // Reason the core stopped, as reported on halt_code.
   localparam logic [1:0] HALT_NONE    = 2'd0;
   localparam logic [1:0] HALT_EBREAK  = 2'd1;
   localparam logic [1:0] HALT_ILLEGAL = 2'd2;
   localparam logic [1:0] HALT_TIMEOUT = 2'd3;

   // Encoding of the ebreak instruction (the decoder compares against it).
   localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

   // True for the states that wait on a memory response and therefore
   // run the timeout counter.
   function automatic logic is_wait_state(input ctrl_state_e s);
      return (s == S_IF) || (s == S_MEM);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050612_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050612_perf_cnt
//  Purpose  : 64-bit cycle and retired-instruction counters. Both counters
//             wrap modulo 2^64. Kept separate so that a later pipelined
//             control block can reuse the same counters.
//  Ports    : clk        in   core clock
//             rst_n      in   asynchronous active-low reset
//             en_cycle   in   count this cycle in mcycle
//             en_retire  in   one instruction retires this cycle
//             mcycle     out  cycle count
//             minstret   out  retired-instruction count
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050612_perf_cnt (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en_cycle,
   input  logic        en_retire,
   output logic [63:0] mcycle,
   output logic [63:0] minstret
);

   logic [63:0] r_mcycle;
   logic [63:0] r_minstret;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcycle <= '0;
      end else if (en_cycle) begin
         r_mcycle <= r_mcycle + 64'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_minstret <= '0;
      end else if (en_retire) begin
         r_minstret <= r_minstret + 64'd1;
      end
   end

   assign mcycle   = r_mcycle;
   assign minstret = r_minstret;

endmodule
`default_nettype wire

// File: rtl/ysyx_22050612_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050612_ctrl
//  Purpose  : Multi-cycle control sequencer for the RV64 core. Steps each
//             instruction through IF, ID, EX, MEM and WB, drives the memory,
//             register-file and PC strobes, latches the fetched instruction
//             for the decoder, and halts on ebreak, an illegal instruction
//             or a memory response timeout.
//  Ports    : clk          in   core clock
//             rst_n        in   asynchronous active-low reset
//             imem_req     out  instruction fetch request
//             imem_rvalid  in   instruction response valid
//             imem_rdata   in   instruction word
//             inst_q       out  latched instruction, to the decoder
//             dec_is_load  in   decoder: load class
//             dec_is_store in   decoder: store class
//             dec_rf_we    in   decoder: instruction writes rd
//             dec_ebreak   in   decoder: inst_q is ebreak
//             dec_illegal  in   decoder: no opcode matched
//             dmem_req     out  data access request
//             dmem_we      out  data access is a store
//             dmem_rvalid  in   data response / store acknowledge
//             rf_we        out  register-file write strobe
//             pc_we        out  PC update strobe
//             halted       out  core stopped
//             halt_code    out  0 running, 1 ebreak, 2 illegal, 3 timeout
//             mcycle       out  cycle counter
//             minstret     out  retired-instruction counter
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050612_ctrl
   import ysyx_22050612_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst_q,
   input  logic        dec_is_load,
   input  logic        dec_is_store,
   input  logic        dec_rf_we,
   input  logic        dec_ebreak,
   input  logic        dec_illegal,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_rvalid,
   output logic        rf_we,
   output logic        pc_we,
   output logic        halted,
   output logic [1:0]  halt_code,
   output logic [63:0] mcycle,
   output logic [63:0] minstret
);

   // Wait-counter width: enough to hold TIMEOUT itself. A TIMEOUT of zero
   // still needs one bit of storage.
   localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] c_wait_max = WAIT_W'(TIMEOUT);

   ctrl_state_e       r_state;
   logic [31:0]       r_inst_q;
   logic [1:0]        r_halt_code;
   logic [WAIT_W-1:0] r_wait;

   logic w_resp;
   logic w_wait_expired;
   logic w_en_cycle;
   logic w_en_retire;

   // Response that the current wait state is looking for. Responses seen in
   // any other state are simply never consulted, which is what makes stray
   // or post-reset responses harmless.
   assign w_resp = (r_state == S_IF) ? imem_rvalid : dmem_rvalid;

   assign w_wait_expired = (r_wait == c_wait_max);

   // -------------------------------------------------------------------------
   // Sequencer. A response in the same cycle that the wait counter reaches
   // its limit is accepted: the response test comes before the limit test.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_inst_q    <= '0;
         r_halt_code <= HALT_NONE;
         r_wait      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state <= S_IF;
               r_wait  <= '0;
            end

            S_IF: begin
               if (w_resp) begin
                  r_inst_q <= imem_rdata;
                  r_state  <= S_ID;
               end else if (w_wait_expired) begin
                  r_state     <= S_HALT;
                  r_halt_code <= HALT_TIMEOUT;
               end else begin
                  r_wait <= r_wait + WAIT_W'(1);
               end
            end

            S_ID: begin
               if (dec_ebreak) begin
                  r_state     <= S_HALT;
                  r_halt_code <= HALT_EBREAK;
               end else if (dec_illegal) begin
                  r_state     <= S_HALT;
                  r_halt_code <= HALT_ILLEGAL;
               end else begin
                  r_state <= S_EX;
               end
            end

            S_EX: begin
               if (dec_is_load || dec_is_store) begin
                  r_state <= S_MEM;
                  r_wait  <= '0;
               end else begin
                  r_state <= S_WB;
               end
            end

            S_MEM: begin
               if (w_resp) begin
                  r_state <= S_WB;
               end else if (w_wait_expired) begin
                  r_state     <= S_HALT;
                  r_halt_code <= HALT_TIMEOUT;
               end else begin
                  r_wait <= r_wait + WAIT_W'(1);
               end
            end

            S_WB: begin
               r_state <= S_IF;
               r_wait  <= '0;
            end

            S_HALT: begin
               r_state <= S_HALT;
            end

            default: begin
               // Unreachable encoding: restart cleanly.
               r_state     <= S_IDLE;
               r_halt_code <= HALT_NONE;
               r_wait      <= '0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Moore strobes, decoded from the state register only (plus the decoder
   // flags, which are themselves a function of the registered inst_q).
   // Nothing here depends on an rvalid input.
   // -------------------------------------------------------------------------
   assign imem_req  = (r_state == S_IF);
   assign dmem_req  = (r_state == S_MEM);
   assign dmem_we   = (r_state == S_MEM) && dec_is_store;
   assign pc_we     = (r_state == S_WB);
   // A store must never write rd, whatever the decoder says about rd.
   assign rf_we     = (r_state == S_WB) && dec_rf_we && !dec_is_store;
   assign halted    = (r_state == S_HALT);
   assign halt_code = r_halt_code;
   assign inst_q    = r_inst_q;

   // ebreak retires in ID on its way to HALT; every other instruction
   // retires in WB.
   assign w_en_cycle  = (r_state != S_HALT);
   assign w_en_retire = (r_state == S_WB) || ((r_state == S_ID) && dec_ebreak);

   ysyx_22050612_perf_cnt u_perf_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_cycle  (w_en_cycle),
      .en_retire (w_en_retire),
      .mcycle    (mcycle),
      .minstret  (minstret)
   );

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050612_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_22050612_ctrl
//  Purpose  : Self-checking bench for the control sequencer. Each table row
//             resets the core, feeds one instruction with given imem/dmem
//             response delays and compares cycle counts, strobe counts,
//             halt status and counters. Hand-written sequences cover halt
//             freezing and an asynchronous reset in the middle of MEM.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050612_ctrl;

   localparam int TIMEOUT = 3;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] inst_q;
   logic        dec_is_load;
   logic        dec_is_store;
   logic        dec_rf_we;
   logic        dec_ebreak;
   logic        dec_illegal;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_rvalid;
   logic        rf_we;
   logic        pc_we;
   logic        halted;
   logic [1:0]  halt_code;
   logic [63:0] mcycle;
   logic [63:0] minstret;

   int checks   = 0;
   int failures = 0;

   ysyx_22050612_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_req     (imem_req),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .inst_q       (inst_q),
      .dec_is_load  (dec_is_load),
      .dec_is_store (dec_is_store),
      .dec_rf_we    (dec_rf_we),
      .dec_ebreak   (dec_ebreak),
      .dec_illegal  (dec_illegal),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_rvalid  (dmem_rvalid),
      .rf_we        (rf_we),
      .pc_we        (pc_we),
      .halted       (halted),
      .halt_code    (halt_code),
      .mcycle       (mcycle),
      .minstret     (minstret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Small decoder model driven from inst_q. The rd-write flag is loose on
   // purpose (stores report it too) so that the store mask in the sequencer
   // is exercised.
   logic [6:0] op;
   always_comb begin
      op           = inst_q[6:0];
      dec_is_load  = (op == 7'h03);
      dec_is_store = (op == 7'h23);
      dec_ebreak   = (inst_q == 32'h0010_0073);
      dec_rf_we    = (op == 7'h03) || (op == 7'h23) || (op == 7'h13) ||
                     (op == 7'h33) || (op == 7'h37) || (op == 7'h17) ||
                     (op == 7'h6f) || (op == 7'h67) || (op == 7'h1b) ||
                     (op == 7'h3b);
      dec_illegal  = !(dec_rf_we || dec_ebreak || (op == 7'h63) || (op == 7'h0f));
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Hold reset for two cycles and release it on a falling edge, so the
   // caller starts sampling in the IDLE cycle.
   task automatic do_reset();
      rst_n       = 1'b0;
      imem_rvalid = 1'b0;
      dmem_rvalid = 1'b0;
      imem_rdata  = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Runs one instruction from the IDLE cycle until WB (plus one cycle so
   // the WB updates are visible) or until the core halts.
   task automatic run_inst(input logic [31:0] inst, input int idly, input int ddly,
                           output int cyc, output int n_ireq, output int n_dreq,
                           output int n_dwe, output int n_pc, output int n_rf,
                           output logic done);
      int ireq_n;
      int dreq_n;
      ireq_n = 0; dreq_n = 0;
      cyc = 0; n_ireq = 0; n_dreq = 0; n_dwe = 0; n_pc = 0; n_rf = 0;
      done = 1'b0;
      imem_rdata = inst;
      for (int k = 0; k < 60 && !done; k++) begin
         if (halted) begin
            done = 1'b1;
         end else begin
            cyc++;
            if (imem_req) begin
               n_ireq++;
               imem_rvalid = (ireq_n >= idly);
               ireq_n++;
            end else begin
               imem_rvalid = 1'b0;
            end
            if (dmem_req) begin
               n_dreq++;
               dmem_rvalid = (dreq_n >= ddly);
               dreq_n++;
            end else begin
               dmem_rvalid = 1'b0;
            end
            if (dmem_we) n_dwe++;
            if (rf_we)   n_rf++;
            if (pc_we) begin
               n_pc++;
               done = 1'b1;
            end
            @(negedge clk);
         end
      end
      imem_rvalid = 1'b0;
      dmem_rvalid = 1'b0;
   endtask

   typedef struct {
      logic [31:0] inst;
      int          idly;
      int          ddly;
      int          cyc;
      int          n_ireq;
      int          n_dreq;
      int          n_dwe;
      int          n_pc;
      int          n_rf;
      logic        hlt;
      logic [1:0]  code;
      logic [63:0] mcyc;
      logic [63:0] minst;
      logic [31:0] iq;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs[NV];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int cyc, n_ireq, n_dreq, n_dwe, n_pc, n_rf;
      logic done;
      logic [63:0] m_frozen;
      int seen;

      //               inst          idly ddly cyc ireq dreq dwe pc rf hlt  code  mcyc   minst  inst_q
      vecs[0]  = '{32'h0010_0093,   0,   0,  5,  1,   0,  0, 1, 1, 1'b0, 2'd0, 64'd5, 64'd1, 32'h0010_0093}; // addi
      vecs[1]  = '{32'h00B1_3023,   0,   3,  9,  1,   4,  4, 1, 0, 1'b0, 2'd0, 64'd9, 64'd1, 32'h00B1_3023}; // sd, late ack
      vecs[2]  = '{32'h0001_3083,   2,   0,  8,  3,   1,  0, 1, 1, 1'b0, 2'd0, 64'd8, 64'd1, 32'h0001_3083}; // ld, late fetch
      vecs[3]  = '{32'h0010_0073,   1,   0,  4,  2,   0,  0, 0, 0, 1'b1, 2'd1, 64'd4, 64'd1, 32'h0010_0073}; // ebreak
      vecs[4]  = '{32'hFFFF_FFFF,   0,   0,  3,  1,   0,  0, 0, 0, 1'b1, 2'd2, 64'd3, 64'd0, 32'hFFFF_FFFF}; // illegal
      vecs[5]  = '{32'h0010_0093, 100,   0,  5,  4,   0,  0, 0, 0, 1'b1, 2'd3, 64'd5, 64'd0, 32'h0000_0000}; // imem timeout
      vecs[6]  = '{32'h0010_0093,   3,   0,  8,  4,   0,  0, 1, 1, 1'b0, 2'd0, 64'd8, 64'd1, 32'h0010_0093}; // rvalid at limit
      vecs[7]  = '{32'h0020_81B3,   0,   0,  5,  1,   0,  0, 1, 1, 1'b0, 2'd0, 64'd5, 64'd1, 32'h0020_81B3}; // add
      vecs[8]  = '{32'h0011_2023,   0,   0,  6,  1,   1,  1, 1, 0, 1'b0, 2'd0, 64'd6, 64'd1, 32'h0011_2023}; // sw
      vecs[9]  = '{32'h0001_3083,   0, 100,  8,  1,   4,  0, 0, 0, 1'b1, 2'd3, 64'd8, 64'd0, 32'h0001_3083}; // dmem timeout
      vecs[10] = '{32'h0001_3083,   0,   3,  9,  1,   4,  0, 1, 1, 1'b0, 2'd0, 64'd9, 64'd1, 32'h0001_3083}; // ld, ack at limit

      // Reset state, sampled in the IDLE cycle right after release.
      do_reset();
      chk("rst_imem_req",  {63'd0, imem_req},  64'd0);
      chk("rst_dmem_req",  {63'd0, dmem_req},  64'd0);
      chk("rst_strobes",   {61'd0, dmem_we, rf_we, pc_we}, 64'd0);
      chk("rst_halted",    {63'd0, halted},    64'd0);
      chk("rst_halt_code", {62'd0, halt_code}, 64'd0);
      chk("rst_inst_q",    {32'd0, inst_q},    64'd0);
      chk("rst_mcycle",    mcycle,             64'd0);
      chk("rst_minstret",  minstret,           64'd0);

      for (int v = 0; v < NV; v++) begin
         if (v != 0) do_reset();
         run_inst(vecs[v].inst, vecs[v].idly, vecs[v].ddly,
                  cyc, n_ireq, n_dreq, n_dwe, n_pc, n_rf, done);
         chk($sformatf("v%0d_done", v),      {63'd0, done},       64'd1);
         chk($sformatf("v%0d_cycles", v),    64'(cyc),            64'(vecs[v].cyc));
         chk($sformatf("v%0d_imem_req", v),  64'(n_ireq),         64'(vecs[v].n_ireq));
         chk($sformatf("v%0d_dmem_req", v),  64'(n_dreq),         64'(vecs[v].n_dreq));
         chk($sformatf("v%0d_dmem_we", v),   64'(n_dwe),          64'(vecs[v].n_dwe));
         chk($sformatf("v%0d_pc_we", v),     64'(n_pc),           64'(vecs[v].n_pc));
         chk($sformatf("v%0d_rf_we", v),     64'(n_rf),           64'(vecs[v].n_rf));
         chk($sformatf("v%0d_halted", v),    {63'd0, halted},     {63'd0, vecs[v].hlt});
         chk($sformatf("v%0d_halt_code", v), {62'd0, halt_code},  {62'd0, vecs[v].code});
         chk($sformatf("v%0d_mcycle", v),    mcycle,              vecs[v].mcyc);
         chk($sformatf("v%0d_minstret", v),  minstret,            vecs[v].minst);
         chk($sformatf("v%0d_inst_q", v),    {32'd0, inst_q},     {32'd0, vecs[v].iq});

         // Once halted, the core must stay put with counters frozen even if
         // responses keep arriving.
         if (vecs[v].hlt) begin
            m_frozen    = mcycle;
            imem_rvalid = 1'b1;
            dmem_rvalid = 1'b1;
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_frz_mcycle", v), mcycle, m_frozen);
            chk($sformatf("v%0d_frz_minstret", v), minstret, vecs[v].minst);
            chk($sformatf("v%0d_frz_strobes", v),
                {59'd0, imem_req, dmem_req, dmem_we, rf_we, pc_we}, 64'd0);
            chk($sformatf("v%0d_frz_halted", v), {63'd0, halted}, 64'd1);
            imem_rvalid = 1'b0;
            dmem_rvalid = 1'b0;
         end
      end

      // Asynchronous reset while a load waits in MEM.
      do_reset();
      imem_rdata = 32'h0001_3083;
      seen = 0;
      for (int k = 0; k < 20 && seen < 2; k++) begin
         imem_rvalid = imem_req;
         if (dmem_req) seen++;
         if (seen < 2) @(negedge clk);
      end
      chk("mid_mem_reached", 64'(seen), 64'd2);
      imem_rvalid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_strobes", {59'd0, imem_req, dmem_req, dmem_we, rf_we, pc_we}, 64'd0);
      chk("arst_halt",    {61'd0, halted, halt_code}, 64'd0);
      chk("arst_inst_q",  {32'd0, inst_q}, 64'd0);
      chk("arst_mcycle",  mcycle,   64'd0);
      chk("arst_minstret", minstret, 64'd0);
      @(negedge clk);
      @(negedge clk);
      // Release with stale responses on both buses.
      rst_n       = 1'b1;
      dmem_rvalid = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0010_0073;
      chk("post_idle_imem_req", {63'd0, imem_req}, 64'd0);
      @(negedge clk);
      chk("post_if_imem_req", {63'd0, imem_req}, 64'd1);
      chk("post_if_inst_q",   {32'd0, inst_q},   64'd0);
      imem_rvalid = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("post_stale_dmem_req", {62'd0, dmem_req, pc_we}, 64'd0);
         chk("post_stale_in_if",    {63'd0, imem_req},        64'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
